// File: rtl/core_pkg.sv
// Shared types for the front end of the core: machine width, the
// {pc, instr} record handed to decode, and the fetch controller states.
package core_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        FETCH,
        DRAIN
    } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear and simultaneous push/pop.
// The head word is read combinationally from storage.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the pointers decide what is live.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

    assert property (@(posedge clk) disable iff (rst || clear) !(push && full && !pop));
    assert property (@(posedge clk) disable iff (rst || clear) !(pop && empty));

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: issues in-order imem reads from pc_in, tags responses with
// their PC and queues them for decode; a flush drops every in-flight fetch.
module fetch_stage
    import core_pkg::*;
#(
    parameter int FIFO_DEPTH      = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    output logic            pc_advance,
    input  logic            flush,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr
);

    localparam int OW = $clog2(MAX_OUTSTANDING+1);
    localparam int CW = $clog2(FIFO_DEPTH+1);

    fetch_state_e    state_q, state_d;
    logic [OW-1:0]   outstanding_q, outstanding_d;
    logic [OW-1:0]   drop_cnt_q, drop_cnt_d;
    logic            req_valid;
    logic            accept;
    logic            keep_rsp;
    logic            id_pop;

    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            fifo_full;
    fetch_entry_t    head_entry;
    fetch_entry_t    rsp_entry;

    logic [XLEN-1:0] addr_head;
    logic [OW-1:0]   aq_count;
    logic            aq_empty;
    logic            aq_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // Credit check counts in-flight requests against free buffer slots so
    // that every response is guaranteed a place to land.
    always_comb begin
        state_d       = state_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;

        req_valid = !rst && !flush && (state_q == FETCH)
                 && (int'(outstanding_q) + int'(fifo_count) < FIFO_DEPTH)
                 && (int'(outstanding_q) < MAX_OUTSTANDING);
        accept    = req_valid && imem_req_ready;
        keep_rsp  = imem_rsp_valid && !flush && (drop_cnt_q == '0);

        case ({accept, imem_rsp_valid})
            2'b10:   outstanding_d = outstanding_q + OW'(1);
            2'b01:   outstanding_d = outstanding_q - OW'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (flush) begin
            drop_cnt_d = imem_rsp_valid ? outstanding_q - OW'(1) : outstanding_q;
            state_d    = (drop_cnt_d != '0) ? DRAIN : FETCH;
        end else begin
            if (imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - OW'(1);
            if (state_q == DRAIN && drop_cnt_d == '0) state_d = FETCH;
        end
    end

    assign imem_req_valid = req_valid;
    assign pc_advance     = accept;
    assign imem_req_addr  = {pc_in[XLEN-1:2], 2'b00};

    assign id_valid = !fifo_empty;
    assign id_pop   = id_valid && id_ready && !flush;
    assign id_pc    = id_valid ? head_entry.pc    : '0;
    assign id_instr = id_valid ? head_entry.instr : '0;

    assign rsp_entry.pc    = addr_head;
    assign rsp_entry.instr = imem_rsp_data;

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_instr_buf (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (keep_rsp),
        .push_data (rsp_entry),
        .pop       (id_pop),
        .head      (head_entry),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Address queue is never cleared by flush: dropped responses still pop it.
    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUTSTANDING)
    ) u_addr_q (
        .clk       (clk),
        .rst       (rst),
        .clear     (1'b0),
        .push      (accept),
        .push_data (pc_in),
        .pop       (imem_rsp_valid),
        .head      (addr_head),
        .count     (aq_count),
        .empty     (aq_empty),
        .full      (aq_full)
    );

    assert property (@(posedge clk) disable iff (rst) imem_rsp_valid |-> (outstanding_q != '0));
    assert property (@(posedge clk) disable iff (rst) drop_cnt_q <= outstanding_q);
    assert property (@(posedge clk) disable iff (rst) aq_count == outstanding_q);
    assert property (@(posedge clk) disable iff (rst) imem_rsp_valid |-> !aq_empty);
    assert property (@(posedge clk) disable iff (rst) !(accept && aq_full));
    assert property (@(posedge clk) disable iff (rst) keep_rsp |-> (!fifo_full || id_pop));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a behavioural fixed-latency imem plus a
// PC register, checked against hand-computed per-cycle expectations.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_advance;
    logic        flush;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    int total = 0;
    int bad   = 0;
    int lat   = 1;
    int cyc   = 0;
    logic last_adv;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pq[$];

    typedef struct {
        bit          rst_before;
        bit          mem_rdy;
        bit          id_rdy;
        bit          e_adv;
        bit          e_rv;
        bit          e_iv;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    localparam int NV = 21;
    vec_t vt [NV];

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .pc_advance     (pc_advance),
        .flush          (flush),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instrOf(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0, a[15:0]};
    endfunction

    // Memory answers each accepted request exactly lat cycles later, in order.
    always @(posedge clk) begin
        if (rst) pq.delete();
        else if (imem_req_valid && imem_req_ready) pq.push_back('{imem_req_addr, cyc + lat});
        #1;
        cyc = cyc + 1;
        imem_rsp_valid = 1'b0;
        if (pq.size() > 0 && pq[0].due == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instrOf(pq[0].addr);
            void'(pq.pop_front());
        end
    end

    task automatic compare(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input bit mem_rdy, input bit id_rdy, input bit fl);
        imem_req_ready = mem_rdy;
        id_ready       = id_rdy;
        flush          = fl;
    endtask

    task automatic checkOutput(input string name, input bit e_adv, input bit e_rv, input bit e_iv,
                               input logic [31:0] e_pc, input logic [31:0] e_instr);
        @(negedge clk);
        compare({name, ".adv"},   {31'h0, pc_advance},     {31'h0, e_adv});
        compare({name, ".rv"},    {31'h0, imem_req_valid}, {31'h0, e_rv});
        compare({name, ".iv"},    {31'h0, id_valid},       {31'h0, e_iv});
        compare({name, ".pc"},    id_pc,    e_pc);
        compare({name, ".instr"}, id_instr, e_instr);
        if (e_rv) compare({name, ".addr"}, imem_req_addr, pc_in & 32'hFFFF_FFFC);
        last_adv = pc_advance;
    endtask

    task automatic advanceClock();
        @(posedge clk);
        #2;
        if (last_adv) pc_in = pc_in + 32'd4;
    endtask

    task automatic runCycle(input string name, input bit m, input bit i, input bit f,
                            input bit e_adv, input bit e_rv, input bit e_iv,
                            input logic [31:0] e_pc, input logic [31:0] e_instr);
        applyStimulus(m, i, f);
        checkOutput(name, e_adv, e_rv, e_iv, e_pc, e_instr);
        advanceClock();
    endtask

    task automatic doReset(input int l);
        lat = l;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        pc_in = 32'h0;
        @(posedge clk);
        #2;
        checkOutput("reset", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        pc_in = 32'h0;

        // Streaming with decode always ready
        vt[0]  = '{1, 1, 1, 1, 1, 0, 32'h0, 32'h0};
        vt[1]  = '{0, 1, 1, 1, 1, 0, 32'h0, 32'h0};
        vt[2]  = '{0, 1, 1, 0, 0, 1, 32'h0, 32'hC0DE_0000};
        vt[3]  = '{0, 1, 1, 1, 1, 1, 32'h4, 32'hC0DE_0004};
        vt[4]  = '{0, 1, 1, 1, 1, 0, 32'h0, 32'h0};
        vt[5]  = '{0, 1, 1, 0, 0, 1, 32'h8, 32'hC0DE_0008};
        // Decode stalled until the buffer fills, then released
        vt[6]  = '{1, 1, 0, 1, 1, 0, 32'h0, 32'h0};
        vt[7]  = '{0, 1, 0, 1, 1, 0, 32'h0, 32'h0};
        vt[8]  = '{0, 1, 0, 0, 0, 1, 32'h0, 32'hC0DE_0000};
        vt[9]  = '{0, 1, 0, 0, 0, 1, 32'h0, 32'hC0DE_0000};
        vt[10] = '{0, 1, 0, 0, 0, 1, 32'h0, 32'hC0DE_0000};
        vt[11] = '{0, 1, 1, 0, 0, 1, 32'h0, 32'hC0DE_0000};
        vt[12] = '{0, 1, 1, 1, 1, 1, 32'h4, 32'hC0DE_0004};
        vt[13] = '{0, 1, 1, 1, 1, 0, 32'h0, 32'h0};
        vt[14] = '{0, 1, 1, 0, 0, 1, 32'h8, 32'hC0DE_0008};
        // Memory not ready for three cycles
        vt[15] = '{1, 0, 1, 0, 1, 0, 32'h0, 32'h0};
        vt[16] = '{0, 0, 1, 0, 1, 0, 32'h0, 32'h0};
        vt[17] = '{0, 0, 1, 0, 1, 0, 32'h0, 32'h0};
        vt[18] = '{0, 1, 1, 1, 1, 0, 32'h0, 32'h0};
        vt[19] = '{0, 1, 1, 1, 1, 0, 32'h0, 32'h0};
        vt[20] = '{0, 1, 1, 0, 0, 1, 32'h0, 32'hC0DE_0000};

        for (int k = 0; k < NV; k++) begin
            if (vt[k].rst_before) doReset(1);
            runCycle($sformatf("vec%0d", k), vt[k].mem_rdy, vt[k].id_rdy, 1'b0,
                     vt[k].e_adv, vt[k].e_rv, vt[k].e_iv, vt[k].e_pc, vt[k].e_instr);
        end

        $display("[TB] flush with two requests in flight, latency 3");
        doReset(3);
        pc_in = 32'h10;
        runCycle("s4c0", 1, 1, 0, 1, 1, 0, 32'h0, 32'h0);
        runCycle("s4c1", 1, 1, 0, 1, 1, 0, 32'h0, 32'h0);
        pc_in = 32'h100;
        runCycle("s4flush", 1, 1, 1, 0, 0, 0, 32'h0, 32'h0);
        runCycle("s4c3", 1, 1, 0, 0, 0, 0, 32'h0, 32'h0);
        runCycle("s4c4", 1, 1, 0, 0, 0, 0, 32'h0, 32'h0);
        runCycle("s4c5", 1, 1, 0, 1, 1, 0, 32'h0, 32'h0);
        runCycle("s4c6", 1, 1, 0, 1, 1, 0, 32'h0, 32'h0);
        runCycle("s4c7", 1, 1, 0, 0, 0, 0, 32'h0, 32'h0);
        runCycle("s4c8", 1, 1, 0, 0, 0, 0, 32'h0, 32'h0);
        runCycle("s4c9", 1, 1, 0, 0, 0, 1, 32'h100, 32'hC0DE_0100);

        $display("[TB] flush coinciding with response and decode pop");
        doReset(1);
        runCycle("s5a_c0", 1, 0, 0, 1, 1, 0, 32'h0, 32'h0);
        runCycle("s5a_c1", 1, 0, 0, 1, 1, 0, 32'h0, 32'h0);
        pc_in = 32'h200;
        runCycle("s5a_flush", 1, 1, 1, 0, 0, 1, 32'h0, 32'hC0DE_0000);
        runCycle("s5a_c3", 1, 1, 0, 1, 1, 0, 32'h0, 32'h0);
        runCycle("s5a_c4", 1, 1, 0, 1, 1, 0, 32'h0, 32'h0);
        runCycle("s5a_c5", 1, 1, 0, 0, 0, 1, 32'h200, 32'hC0DE_0200);

        $display("[TB] flush coinciding with response, one request left in flight");
        doReset(2);
        runCycle("s5b_c0", 1, 1, 0, 1, 1, 0, 32'h0, 32'h0);
        runCycle("s5b_c1", 1, 1, 0, 1, 1, 0, 32'h0, 32'h0);
        pc_in = 32'h300;
        runCycle("s5b_flush", 1, 1, 1, 0, 0, 0, 32'h0, 32'h0);
        runCycle("s5b_c3", 1, 1, 0, 0, 0, 0, 32'h0, 32'h0);
        runCycle("s5b_c4", 1, 1, 0, 1, 1, 0, 32'h0, 32'h0);
        runCycle("s5b_c5", 1, 1, 0, 1, 1, 0, 32'h0, 32'h0);
        runCycle("s5b_c6", 1, 1, 0, 0, 0, 0, 32'h0, 32'h0);
        runCycle("s5b_c7", 1, 1, 0, 0, 0, 1, 32'h300, 32'hC0DE_0300);

        $display("[TB] reset mid-operation");
        doReset(1);
        runCycle("s6c0", 1, 0, 0, 1, 1, 0, 32'h0, 32'h0);
        runCycle("s6c1", 1, 0, 0, 1, 1, 0, 32'h0, 32'h0);
        rst = 1'b1;
        runCycle("s6rst", 1, 0, 0, 0, 0, 1, 32'h0, 32'hC0DE_0000);
        runCycle("s6held", 1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        rst = 1'b0;
        pc_in = 32'h40;
        runCycle("s6c4", 1, 1, 0, 1, 1, 0, 32'h0, 32'h0);
        runCycle("s6c5", 1, 1, 0, 1, 1, 0, 32'h0, 32'h0);
        runCycle("s6c6", 1, 1, 0, 0, 0, 1, 32'h40, 32'hC0DE_0040);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
